// File: rtl/ysyx_wb_arbiter.sv
// ysyx_wb_arbiter: writeback arbiter in front of the register file.
// Two producers (A = execute/ALU, B = load/multi-cycle) offer results over
// valid/ready. One result per cycle is granted with round-robin priority
// and written through a registered single write port. Writes to x0 are
// swallowed. A counter tracks committed (rd != 0) writes.
//
// Optional feature: define YSYX_WB_TRACE_EN to compile a simulation-only
// per-write trace. The synthesizable logic is the same with or without it.
module ysyx_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // Port A: execute/ALU results
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_rd,
  input  logic [XLEN-1:0]  a_data,
  // Port B: load/multi-cycle results
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_rd,
  input  logic [XLEN-1:0]  b_data,
  // Global hold-off
  input  logic             wb_stall,
  // Register-file write port
  output logic             rf_wr_en,
  output logic [4:0]       waddr,
  output logic [XLEN-1:0]  wdata,
  // Committed-write counter
  output logic [CNT_W-1:0] wb_count
);

  // Priority pointer: 0 favours A, 1 favours B when both are valid.
  logic             prio_q,     prio_d;
  logic             wr_en_q,    wr_en_d;
  logic [4:0]       waddr_q,    waddr_d;
  logic [XLEN-1:0]  wdata_q,    wdata_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic             grant_a;
  logic             grant_b;
  logic             xfer;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             commit;

  // Combinational round-robin grant; ready is masked by stall and by reset
  // so no producer sees an accept while the block is held in reset.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && !wb_stall) begin
      if (a_valid && b_valid) begin
        grant_a = ~prio_q;
        grant_b =  prio_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // A ready is only ever raised for a valid port, so any ready is a transfer.
  assign xfer     = grant_a | grant_b;
  assign sel_rd   = grant_b ? b_rd   : a_rd;
  assign sel_data = grant_b ? b_data : a_data;
  assign commit   = xfer && (sel_rd != 5'd0);

  // Next-state for pointer, write port and counter.
  always_comb begin
    prio_d  = prio_q;
    wr_en_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    // After a transfer the pointer favours the port that was not served.
    if (xfer) begin
      prio_d = grant_a;
    end
    // x0 transfers complete the handshake but leave the write port idle.
    if (commit) begin
      wr_en_d = 1'b1;
      waddr_d = sel_rd;
      wdata_d = sel_data;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // State registers; asynchronous reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      prio_q  <= 1'b0;
      wr_en_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      prio_q  <= prio_d;
      wr_en_q <= wr_en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_wr_en = wr_en_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign wb_count = cnt_q;

`ifdef YSYX_WB_TRACE_EN
  // Simulation-only trace: remembers which port fed the current strobe and
  // prints one line per register-file write.
  logic trace_src_q;

  // Print the write visible during the cycle that just ended, then record
  // the source of the transfer taking place in that same cycle.
  always @(posedge clk) begin
    if (rst_n && wr_en_q) begin
      $display("[ysyx_wb_arbiter] src=%s waddr=%0d wdata=%h wb_count=%0d",
               trace_src_q ? "B" : "A", waddr_q, wdata_q, cnt_q);
    end
    if (xfer) begin
      trace_src_q <= grant_b;
    end
  end
`endif

endmodule
